// File: rtl/aes_ctr_stream.sv
// AES-CTR streaming controller: builds {nonce, counter} blocks, drives an external block core,
// XORs keystream into the data stream. Define AES_CTR_PREFETCH_EN for one-entry keystream prefetch.
module aes_ctr_stream #(
    parameter int          CTR_W    = 32,
    parameter int          LEN_W    = 16,
    parameter logic [63:0] CTR_INIT = 64'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [127-CTR_W:0]   nonce_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [127:0]         in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [127:0]         out_data_o,
    output logic                 core_req_o,
    output logic [127:0]         core_blk_o,
    input  logic                 core_ack_i,
    input  logic [127:0]         core_ks_i
);
    localparam int NONCE_W = 128 - CTR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_KWAIT = 3'd2;
    localparam logic [2:0] S_DWAIT = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [127:0]       ks_q, ks_d;
    logic [127:0]       out_data_q, out_data_d;
    logic               err_q, err_d;
    logic               ctr_max;
    logic               last_blk;

    assign ctr_max  = &ctr_q;
    assign last_blk = (rem_q == LEN_W'(1));

    assign busy_o      = (state_q == S_REQ) || (state_q == S_KWAIT) ||
                         (state_q == S_DWAIT) || (state_q == S_OUT);
    assign done_o      = (state_q == S_FIN);
    assign err_o       = err_q;
    assign in_ready_o  = (state_q == S_DWAIT);
    assign out_valid_o = (state_q == S_OUT);
    assign out_data_o  = out_data_q;

`ifdef AES_CTR_PREFETCH_EN
    logic         pf_valid_q, pf_valid_d;
    logic         pf_pend_q, pf_pend_d;
    logic [127:0] pf_ks_q, pf_ks_d;
    logic         pf_issue;
    logic         pf_avail;

    // Prefetch only when a following block exists and its counter does not wrap.
    assign pf_issue   = (state_q == S_DWAIT) && !pf_valid_q && !pf_pend_q &&
                        (rem_q > LEN_W'(1)) && !ctr_max;
    assign pf_avail   = pf_valid_q || (pf_pend_q && core_ack_i);
    assign core_req_o = (state_q == S_REQ) || pf_issue;
    assign core_blk_o = {nonce_q, ctr_q + CTR_W'(pf_issue || pf_pend_q)};
`else
    assign core_req_o = (state_q == S_REQ);
    assign core_blk_o = {nonce_q, ctr_q};
`endif

    always_comb begin
        state_d    = state_q;
        nonce_d    = nonce_q;
        ctr_d      = ctr_q;
        rem_d      = rem_q;
        ks_d       = ks_q;
        out_data_d = out_data_q;
        err_d      = err_q;
`ifdef AES_CTR_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_pend_d  = pf_pend_q;
        pf_ks_d    = pf_ks_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nonce_d = nonce_i;
                    ctr_d   = CTR_INIT[CTR_W-1:0];
                    rem_d   = len_i;
                    err_d   = 1'b0;
                    state_d = (len_i == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: state_d = S_KWAIT;
            S_KWAIT: begin
                if (core_ack_i) begin
                    ks_d    = core_ks_i;
                    state_d = S_DWAIT;
                end
            end
            S_DWAIT: begin
                if (in_valid_i) begin
                    out_data_d = in_data_i ^ ks_q;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    rem_d = rem_q - LEN_W'(1);
                    ctr_d = ctr_q + CTR_W'(1);
                    if (last_blk) begin
                        state_d = S_FIN;
                    end else if (ctr_max) begin
                        // Another block would need the wrapped counter value.
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef AES_CTR_PREFETCH_EN
        if (pf_issue) begin
            pf_pend_d = 1'b1;
        end
        if (pf_pend_q && core_ack_i) begin
            pf_pend_d  = 1'b0;
            pf_valid_d = 1'b1;
            pf_ks_d    = core_ks_i;
        end
        if ((state_q == S_OUT) && out_ready_i && (state_d == S_REQ)) begin
            // A still-pending prefetch becomes the regular request for the new counter.
            if (pf_avail) begin
                ks_d    = pf_valid_q ? pf_ks_q : core_ks_i;
                state_d = S_DWAIT;
            end else if (pf_pend_q) begin
                state_d = S_KWAIT;
            end
            pf_valid_d = 1'b0;
            pf_pend_d  = 1'b0;
        end
        if (state_d == S_FIN) begin
            pf_valid_d = 1'b0;
            pf_pend_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            nonce_q    <= '0;
            ctr_q      <= '0;
            rem_q      <= '0;
            ks_q       <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
`ifdef AES_CTR_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
            pf_ks_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            nonce_q    <= nonce_d;
            ctr_q      <= ctr_d;
            rem_q      <= rem_d;
            ks_q       <= ks_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
`ifdef AES_CTR_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_pend_q  <= pf_pend_d;
            pf_ks_q    <= pf_ks_d;
`endif
        end
    end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// Scoreboard bench for aes_ctr_stream: a 32-bit-counter and an 8-bit-counter instance share
// stimulus; sel chooses which one is exercised and observed.
module tb_aes_ctr_stream;
    localparam int LEN_W = 16;
    localparam logic [127:0] KMASK = 128'h0123456789abcdef_fedcba9876543210;
`ifdef AES_CTR_PREFETCH_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, sel, in_valid, out_ready, core_ack;
    logic [119:0]     nonce;
    logic [127:0]     in_data, core_ks;
    logic [LEN_W-1:0] len;

    logic busy0, done0, err0, in_ready0, out_valid0, core_req0;
    logic busy1, done1, err1, in_ready1, out_valid1, core_req1;
    logic [127:0] out_data0, core_blk0, out_data1, core_blk1;
    logic busy_m, done_m, err_m, in_ready_m, out_valid_m, core_req_m;
    logic [127:0] out_data_m, core_blk_m;

    aes_ctr_stream #(.CTR_W(32), .LEN_W(LEN_W), .CTR_INIT(64'd1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start && !sel), .nonce_i(nonce[95:0]), .len_i(len),
        .busy_o(busy0), .done_o(done0), .err_o(err0),
        .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_data_i(in_data),
        .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(out_data0),
        .core_req_o(core_req0), .core_blk_o(core_blk0), .core_ack_i(core_ack), .core_ks_i(core_ks)
    );

    aes_ctr_stream #(.CTR_W(8), .LEN_W(LEN_W), .CTR_INIT(64'hFE)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start && sel), .nonce_i(nonce), .len_i(len),
        .busy_o(busy1), .done_o(done1), .err_o(err1),
        .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_data_i(in_data),
        .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(out_data1),
        .core_req_o(core_req1), .core_blk_o(core_blk1), .core_ack_i(core_ack), .core_ks_i(core_ks)
    );

    assign busy_m      = sel ? busy1      : busy0;
    assign done_m      = sel ? done1      : done0;
    assign err_m       = sel ? err1       : err0;
    assign in_ready_m  = sel ? in_ready1  : in_ready0;
    assign out_valid_m = sel ? out_valid1 : out_valid0;
    assign core_req_m  = sel ? core_req1  : core_req0;
    assign out_data_m  = sel ? out_data1  : out_data0;
    assign core_blk_m  = sel ? core_blk1  : core_blk0;

    logic [127:0] exp_blk_q[$];
    logic [127:0] exp_out_q[$];
    logic [127:0] pt_q[$];

    int n_checks = 0, n_errors = 0;
    int n_req = 0, n_ack = 0, n_hs = 0, n_done = 0, cyc = 0;
    int done_base = 0, hs_base = 0, core_lat = 0;
    int stall_blk = 0, stall_len = 0, stalled = 0;
    bit gap_en = 0, gap_have = 0;
    int prev_hs_cyc = 0;

    // Stand-in keystream function for the block core (a fixed permutation plus mask).
    function automatic logic [127:0] ks_of(input logic [127:0] b);
        return {b[31:0], b[127:32]} ^ KMASK;
    endfunction

    function automatic logic [127:0] mk_blk(input bit s, input logic [119:0] n, input logic [31:0] c);
        return s ? {n, c[7:0]} : {n[95:0], c};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_blk(input logic [127:0] blk, input logic [127:0] pt);
        exp_blk_q.push_back(blk);
        pt_q.push_back(pt);
        exp_out_q.push_back(pt ^ ks_of(blk));
    endtask

    task automatic do_start(input bit s, input logic [119:0] n, input int l);
        @(posedge clk); #1;
        sel = s; nonce = n; len = LEN_W'(l); start = 1'b1;
        done_base = n_done; hs_base = n_hs;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (n_done == done_base && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 128'(n_done > done_base), 128'd1);
    endtask

    // Core model: answers each request with its keystream core_lat cycles after the minimum.
    initial begin
        logic [127:0] blk;
        core_ack = 1'b0; core_ks = '0;
        forever begin
            @(negedge clk);
            if (core_req_m) begin
                blk = core_blk_m;
                @(posedge clk); #1;
                repeat (core_lat) begin @(posedge clk); #1; end
                core_ack = 1'b1; core_ks = ks_of(blk); n_ack++;
                @(posedge clk); #1;
                core_ack = 1'b0; core_ks = '0;
            end
        end
    end

    // Plaintext source: presents the head of pt_q, pops it after an accepted handshake.
    initial begin
        bit acc;
        in_valid = 1'b0; in_data = '0;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready_m;
            @(posedge clk); #1;
            if (acc && pt_q.size() != 0) void'(pt_q.pop_front());
            in_valid = (pt_q.size() != 0);
            in_data  = in_valid ? pt_q[0] : '0;
        end
    end

    // Sink: optionally holds out_ready low for stall_len cycles on block stall_blk.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (out_valid_m && (n_hs - hs_base == stall_blk - 1) && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: request ordering, output scoreboard, hold stability, handshake spacing.
    initial begin
        logic [127:0] held, exp;
        bit hold_active = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done_m) n_done++;
            if (core_req_m) begin
                chk("req_overlap", 128'(n_req - n_ack), 128'd0);
                n_req++;
                if (exp_blk_q.size() == 0) chk("req_unexpected", core_blk_m, 128'hx);
                else chk("core_blk", core_blk_m, exp_blk_q.pop_front());
            end
            if (out_valid_m) begin
                if (hold_active) chk("out_hold", out_data_m, held);
                if (out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        chk("out_unexpected", out_data_m, 128'hx);
                    end else begin
                        exp = exp_out_q.pop_front();
                        chk("out_data", out_data_m, exp);
                    end
                    n_hs++;
                    $display("out handshake %0d at cycle %0d data=%h", n_hs, cyc, out_data_m);
                    if (gap_en && gap_have) chk("hs_gap", 128'(cyc - prev_hs_cyc), 128'(EXP_GAP));
                    prev_hs_cyc = cyc; gap_have = 1;
                    hold_active = 0;
                end else begin
                    held = out_data_m;
                    hold_active = 1;
                end
            end else begin
                hold_active = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; sel = 1'b0; nonce = '0; len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on both instances
        @(negedge clk);
        chk("rst_ctl0", 128'({busy0, done0, err0, in_ready0, out_valid0, core_req0}), 128'd0);
        chk("rst_data0", out_data0 | core_blk0, 128'd0);
        chk("rst_ctl1", 128'({busy1, done1, err1, in_ready1, out_valid1, core_req1}), 128'd0);
        chk("rst_data1", out_data1 | core_blk1, 128'd0);

        // len=0 completes immediately without a core request
        base = n_req;
        do_start(0, 120'h0, 0);
        @(negedge clk);
        chk("len0_done", 128'(done_m), 128'd1);
        chk("len0_busy", 128'(busy_m), 128'd0);
        chk("len0_err", 128'(err_m), 128'd0);
        @(negedge clk);
        chk("len0_done_pulse", 128'(done_m), 128'd0);
        chk("len0_no_req", 128'(n_req - base), 128'd0);

        // Single block, nonce 0, counter 1
        exp_blk_q.push_back(128'h1);
        pt_q.push_back(128'h0);
        exp_out_q.push_back(128'h01234566_89abcdef_fedcba98_76543210);
        do_start(0, 120'h0, 1);
        @(negedge clk);
        chk("one_busy", 128'(busy_m), 128'd1);
        wait_done("one_done", 100);
        chk("one_hs", 128'(n_hs - hs_base), 128'd1);
        chk("one_err", 128'(err_m), 128'd0);

        // Three blocks with block 2 stalled at the sink, slower core
        core_lat = 2; stall_blk = 2; stall_len = 5; stalled = 0;
        for (int i = 1; i <= 3; i++)
            push_blk(mk_blk(0, 120'hCAFE, 32'(i)), {4{32'h11110000 + 32'(i)}});
        do_start(0, 120'hCAFE, 3);
        wait_done("stall_done", 300);
        chk("stall_hs", 128'(n_hs - hs_base), 128'd3);
        chk("stall_len", 128'(stalled), 128'd5);
        stall_blk = 0; core_lat = 0;

        // 8-bit counter from FE: blocks FE and FF, then exhaustion
        push_blk(mk_blk(1, 120'hABCDEF, 32'hFE), 128'hDEADBEEF);
        push_blk(mk_blk(1, 120'hABCDEF, 32'hFF), 128'hFEEDFACE);
        do_start(1, 120'hABCDEF, 3);
        wait_done("wrap_done", 200);
        chk("wrap_hs", 128'(n_hs - hs_base), 128'd2);
        chk("wrap_err", 128'(err_m), 128'd1);
        repeat (3) @(negedge clk);
        chk("wrap_err_sticky", 128'(err_m), 128'd1);
        push_blk(mk_blk(1, 120'h5, 32'hFE), 128'h77);
        do_start(1, 120'h5, 1);
        @(negedge clk);
        chk("wrap_err_clear", 128'(err_m), 128'd0);
        wait_done("restart_done", 100);
        chk("restart_err", 128'(err_m), 128'd0);

        // Reset while waiting for keystream; the late ack must be ignored
        core_lat = 4;
        exp_blk_q.push_back(mk_blk(0, 120'h77, 32'd1));
        base = n_req;
        do_start(0, 120'h77, 1);
        for (int k = 0; k < 20 && n_req == base; k++) @(negedge clk);
        chk("rst_mid_req", 128'(n_req - base), 128'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_mid_no_out", 128'({out_valid_m, busy_m}), 128'd0);
        end
        chk("rst_mid_no_done", 128'(n_done - done_base), 128'd0);
        core_lat = 0;
        push_blk(mk_blk(0, 120'h5, 32'd1), 128'hA5);
        push_blk(mk_blk(0, 120'h5, 32'd2), 128'h5A);
        do_start(0, 120'h5, 2);
        wait_done("after_rst_done", 100);
        chk("after_rst_hs", 128'(n_hs - hs_base), 128'd2);

        // Streaming throughput with zero-latency core and always-ready ends
        gap_en = 1; gap_have = 0;
        for (int i = 1; i <= 4; i++)
            push_blk(mk_blk(0, 120'h99, 32'(i)), 128'(i * 32'h01010101));
        do_start(0, 120'h99, 4);
        wait_done("tput_done", 100);
        chk("tput_hs", 128'(n_hs - hs_base), 128'd4);
        gap_en = 0;

        repeat (5) @(negedge clk);
        chk("blk_q_empty", 128'(exp_blk_q.size()), 128'd0);
        chk("out_q_empty", 128'(exp_out_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
